smart_house_remote: RTL and testbench

- Command-side transmitter for the smart-house controller; drives the controller's character, temperature and doorbell inputs.
- Serialises a fixed ASCII command string ("openwindow") onto an 8-bit character bus with a per-character valid/ack handshake.
- Also holds a clamped temperature setpoint and stretches doorbell presses into fixed-width ring pulses.
- Sits between the user-panel logic and smart_house_function in the top-level house model.

---
 rtl/smart_house_remote.sv | 258 +++++++++++++++++++++++++
 tb/tb_smart_house_remote.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smart_house_remote.sv
// smart_house_remote: command-side transmitter for the smart-house controller.
// Serialises the ASCII command "openwindow" over an 8-bit character bus with a
// per-character valid/ack handshake, inter-character gaps and an ack timeout.
// It also holds a clamped temperature setpoint and stretches doorbell presses
// into fixed-width ring pulses. Those two paths run independently of the FSM.
//
// Optional build macro: CLOSE_CMD_EN
//   When defined, this adds the send_close input and a second command string,
//   "closewindow". If send_open and send_close arrive in the same idle cycle,
//   send_open wins.
module smart_house_remote #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned GAP_CYCLES     = 1,
    parameter int unsigned RING_CYCLES    = 4,
    parameter int unsigned TEMP_MIN       = 10,
    parameter int unsigned TEMP_MAX       = 40,
    parameter int unsigned TEMP_RESET     = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        send_open,
`ifdef CLOSE_CMD_EN
    input  logic        send_close,
`endif
    input  logic        ack,
    input  logic [31:0] temp_set,
    input  logic        temp_load,
    input  logic        ring_btn,
    output logic [7:0]  char_req,
    output logic        char_valid,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] temp_req,
    output logic        ring_req
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE,
        ST_ABORT
    } state_t;

    localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  GAP_LAST  = 4'(GAP_CYCLES - 1);
    localparam logic [7:0]  RING_LOAD = 8'(RING_CYCLES);
    localparam logic [31:0] T_MIN     = 32'(TEMP_MIN);
    localparam logic [31:0] T_MAX     = 32'(TEMP_MAX);
    localparam logic [31:0] T_RST     = 32'(TEMP_RESET);

    state_t      state;
    state_t      state_n;
    logic [3:0]  idx;
    logic [3:0]  idx_n;
    logic [7:0]  tmo_cnt;
    logic [7:0]  tmo_n;
    logic [3:0]  gap_cnt;
    logic [3:0]  gap_n;
    logic        err_q;
    logic        err_n;

    logic        start;
    logic [3:0]  last_idx;
    logic [7:0]  cur_char;

`ifdef CLOSE_CMD_EN
    logic        sel_close;
    logic        sel_close_n;
`endif

    logic        ring_prev;
    logic [7:0]  ring_cnt;
    logic [31:0] temp_q;

    function automatic logic [7:0] open_char(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h6F; // o
            4'd1:    return 8'h70; // p
            4'd2:    return 8'h65; // e
            4'd3:    return 8'h6E; // n
            4'd4:    return 8'h77; // w
            4'd5:    return 8'h69; // i
            4'd6:    return 8'h6E; // n
            4'd7:    return 8'h64; // d
            4'd8:    return 8'h6F; // o
            4'd9:    return 8'h77; // w
            default: return 8'h00;
        endcase
    endfunction

`ifdef CLOSE_CMD_EN
    function automatic logic [7:0] close_char(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h63; // c
            4'd1:    return 8'h6C; // l
            4'd2:    return 8'h6F; // o
            4'd3:    return 8'h73; // s
            4'd4:    return 8'h65; // e
            4'd5:    return 8'h77; // w
            4'd6:    return 8'h69; // i
            4'd7:    return 8'h6E; // n
            4'd8:    return 8'h64; // d
            4'd9:    return 8'h6F; // o
            4'd10:   return 8'h77; // w
            default: return 8'h00;
        endcase
    endfunction
`endif

    function automatic logic [31:0] clamp_temp(input logic [31:0] v);
        if (v < T_MIN) begin
            return T_MIN;
        end else if (v > T_MAX) begin
            return T_MAX;
        end else begin
            return v;
        end
    endfunction

    // Select the active command string, its last index and the request strobe.
    always_comb begin
`ifdef CLOSE_CMD_EN
        start    = send_open | send_close;
        cur_char = sel_close ? close_char(idx) : open_char(idx);
        last_idx = sel_close ? 4'd10 : 4'd9;
`else
        start    = send_open;
        cur_char = open_char(idx);
        last_idx = 4'd9;
`endif
    end

    // Next-state, index, timeout and gap counters for the transmit FSM.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        tmo_n   = tmo_cnt;
        gap_n   = gap_cnt;
        err_n   = err_q;
`ifdef CLOSE_CMD_EN
        sel_close_n = sel_close;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_SEND;
                    idx_n   = '0;
                    tmo_n   = '0;
                    gap_n   = '0;
                    err_n   = 1'b0;
`ifdef CLOSE_CMD_EN
                    sel_close_n = ~send_open;
`endif
                end
            end
            ST_SEND: begin
                if (ack) begin
                    tmo_n = '0;
                    if (idx == last_idx) begin
                        state_n = ST_DONE;
                    end else begin
                        idx_n = idx + 4'd1;
                        // With no gap the next character goes out back-to-back.
                        if (GAP_CYCLES == 0) begin
                            state_n = ST_SEND;
                        end else begin
                            state_n = ST_GAP;
                            gap_n   = '0;
                        end
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = ST_ABORT;
                    err_n   = 1'b1;
                end else begin
                    tmo_n = tmo_cnt + 8'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = ST_SEND;
                    tmo_n   = '0;
                end else begin
                    gap_n = gap_cnt + 4'd1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            ST_ABORT: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Transmit FSM state register and its counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            tmo_cnt <= '0;
            gap_cnt <= '0;
            err_q   <= 1'b0;
`ifdef CLOSE_CMD_EN
            sel_close <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            tmo_cnt <= tmo_n;
            gap_cnt <= gap_n;
            err_q   <= err_n;
`ifdef CLOSE_CMD_EN
            sel_close <= sel_close_n;
`endif
        end
    end

    // Temperature setpoint: clamp on load, independent of the FSM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            temp_q <= T_RST;
        end else if (temp_load) begin
            temp_q <= clamp_temp(temp_set);
        end
    end

    // Doorbell stretcher: a rising edge (re)loads the counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ring_prev <= 1'b0;
            ring_cnt  <= '0;
        end else begin
            ring_prev <= ring_btn;
            if (ring_btn && !ring_prev) begin
                ring_cnt <= RING_LOAD;
            end else if (ring_cnt != '0) begin
                ring_cnt <= ring_cnt - 8'd1;
            end
        end
    end

    // Outputs are decoded from registered state, so reset clears them at once.
    always_comb begin
        char_valid = (state == ST_SEND);
        char_req   = char_valid ? cur_char : 8'h00;
        busy       = (state == ST_SEND) || (state == ST_GAP);
        done       = (state == ST_DONE);
        error      = err_q;
        temp_req   = temp_q;
        ring_req   = (ring_cnt != '0);
    end

endmodule

// File: tb/tb_smart_house_remote.sv
// tb_smart_house_remote: randomized self-checking bench for smart_house_remote.
// The reference model works at command level: expected character strings,
// gap and timeout lengths, the clamp rule, and ring windows measured from the
// recorded cycles of button edges. Build with CLOSE_CMD_EN to exercise
// "closewindow".
module tb_smart_house_remote;

    localparam int unsigned TMO  = 16;
    localparam int unsigned GAP  = 1;
    localparam int unsigned RING = 4;
    localparam int unsigned TMIN = 10;
    localparam int unsigned TMAX = 40;
    localparam int unsigned TRST = 24;

    logic        clock;
    logic        reset;
    logic        send_open;
`ifdef CLOSE_CMD_EN
    logic        send_close;
`endif
    logic        ack;
    logic [31:0] temp_set;
    logic        temp_load;
    logic        ring_btn;
    logic [7:0]  char_req;
    logic        char_valid;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] temp_req;
    logic        ring_req;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_temp;
    int          cyc;
    int          last_edge;
    bit          prev_btn;
    bit          bg_run;

    smart_house_remote #(
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAP),
        .RING_CYCLES   (RING),
        .TEMP_MIN      (TMIN),
        .TEMP_MAX      (TMAX),
        .TEMP_RESET    (TRST)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .send_open (send_open),
`ifdef CLOSE_CMD_EN
        .send_close(send_close),
`endif
        .ack       (ack),
        .temp_set  (temp_set),
        .temp_load (temp_load),
        .ring_btn  (ring_btn),
        .char_req  (char_req),
        .char_valid(char_valid),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .temp_req  (temp_req),
        .ring_req  (ring_req)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] clamp_ref(input logic [31:0] v);
        if (v < TMIN) return TMIN;
        if (v > TMAX) return TMAX;
        return v;
    endfunction

    function automatic string cmd_text(input int kind);
        return (kind == 1) ? "closewindow" : "openwindow";
    endfunction

    // kind: 0 open, 1 close, 2 both in one cycle (open wins).
    // abort_at: character index that is never acked, or -1.
    task automatic send_cmd(input int kind, input int abort_at, input bit rand_ack, input bit noise);
        string s;
        int    cnt;
        int    d;
        s = cmd_text(kind);
`ifdef CLOSE_CMD_EN
        send_open  = (kind != 1);
        send_close = (kind != 0);
`else
        send_open  = 1'b1;
`endif
        tick();
        send_open = 1'b0;
`ifdef CLOSE_CMD_EN
        send_close = 1'b0;
`endif
        check_eq("busy_start", 32'(busy), 32'd1);
        check_eq("err_clear", 32'(error), 32'd0);
        for (int i = 0; i < s.len(); i++) begin
            cnt = 0;
            while (!char_valid && cnt < 64) begin
                check_eq("gap_char", 32'(char_req), 32'd0);
                check_eq("gap_busy", 32'(busy), 32'd1);
                if (noise) ack = 1'($urandom_range(0, 1));
                tick();
                ack = 1'b0;
                cnt++;
            end
            check_eq("gap_len", 32'(cnt), (i == 0) ? 32'd0 : 32'(GAP));
            check_eq("char", 32'(char_req), 32'(s[i]));
            if (i == abort_at) begin
                cnt = 0;
                while (char_valid && cnt < 600) begin
                    check_eq("hold_char", 32'(char_req), 32'(s[i]));
                    if (noise && $urandom_range(0, 3) == 0) send_open = 1'b1;
                    tick();
                    send_open = 1'b0;
                    cnt++;
                end
                check_eq("tmo_len", 32'(cnt), 32'(TMO));
                check_eq("abort_err", 32'(error), 32'd1);
                check_eq("abort_busy", 32'(busy), 32'd0);
                check_eq("abort_char", 32'(char_req), 32'd0);
                tick();
                check_eq("idle_err", 32'(error), 32'd1);
                check_eq("idle_busy", 32'(busy), 32'd0);
                return;
            end
            d = rand_ack ? int'($urandom_range(0, 5)) : 1;
            repeat (d) begin
                if (noise && $urandom_range(0, 3) == 0) send_open = 1'b1;
                tick();
                send_open = 1'b0;
                check_eq("hold_char", 32'(char_req), 32'(s[i]));
                check_eq("hold_valid", 32'(char_valid), 32'd1);
                check_eq("no_done", 32'(done), 32'd0);
            end
            ack = 1'b1;
            tick();
            ack = 1'b0;
        end
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_valid", 32'(char_valid), 32'd0);
        check_eq("done_err", 32'(error), 32'd0);
        tick();
        check_eq("done_once", 32'(done), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
    endtask

    // Random temperature and doorbell traffic alongside the FSM traffic.
    task automatic bg_loop();
        logic [31:0] v;
        bit          ld;
        bit          b;
        while (bg_run) begin
            ld = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 6))
                0:       v = TMIN - 1;
                1:       v = TMIN;
                2:       v = TMAX;
                3:       v = TMAX + 1;
                4:       v = 32'hFFFF_FFFF;
                5:       v = $urandom_range(0, 60);
                default: v = $urandom;
            endcase
            b = ($urandom_range(0, 4) == 0);
            temp_load = ld;
            temp_set  = v;
            ring_btn  = b;
            tick();
            cyc++;
            if (ld) exp_temp = clamp_ref(v);
            if (b && !prev_btn) last_edge = cyc;
            prev_btn = b;
            check_eq("temp", temp_req, exp_temp);
            check_eq("ring", 32'(ring_req), 32'((cyc - last_edge) < int'(RING)));
        end
        temp_load = 1'b0;
        ring_btn  = 1'b0;
    endtask

    initial begin
        int    cnt;
        int    kind;
        int    ab;
        string s;
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b0;
        send_open  = 1'b0;
`ifdef CLOSE_CMD_EN
        send_close = 1'b0;
`endif
        ack        = 1'b0;
        temp_set   = '0;
        temp_load  = 1'b0;
        ring_btn   = 1'b0;
        bg_run     = 1'b0;

        #12;
        check_eq("rst_valid", 32'(char_valid), 32'd0);
        check_eq("rst_char", 32'(char_req), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(error), 32'd0);
        check_eq("rst_temp", temp_req, 32'(TRST));
        check_eq("rst_ring", 32'(ring_req), 32'd0);
        #10;
        reset = 1'b1;
        tick();

        // Temperature clamp: below, inside and above the range.
        temp_set = 32'd5;   temp_load = 1'b1; tick(); check_eq("temp_lo", temp_req, 32'd10);
        temp_set = 32'd35;  tick(); check_eq("temp_mid", temp_req, 32'd35);
        temp_set = 32'd100; tick(); check_eq("temp_hi", temp_req, 32'd40);
        temp_load = 1'b0;
        temp_set  = 32'd7;
        tick();
        check_eq("temp_hold", temp_req, 32'd40);
        exp_temp = 32'd40;

        // Doorbell: single press, then a re-trigger at pulse cycle 3.
        ring_btn = 1'b1; tick(); ring_btn = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            cnt += int'(ring_req);
            tick();
        end
        check_eq("ring_single", 32'(cnt), 32'(RING));
        ring_btn = 1'b1; tick(); cnt = int'(ring_req);
        ring_btn = 1'b0; tick(); cnt += int'(ring_req);
        ring_btn = 1'b1; tick(); cnt += int'(ring_req);
        ring_btn = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            cnt += int'(ring_req);
        end
        check_eq("ring_extend", 32'(cnt), 32'(RING + 2));

        // Full "openwindow" with one-cycle ack delay, then a timeout.
        send_cmd(0, -1, 1'b0, 1'b0);
        send_cmd(0, 0, 1'b0, 1'b0);
        send_cmd(0, -1, 1'b0, 1'b0);

`ifdef CLOSE_CMD_EN
        send_cmd(2, -1, 1'b0, 1'b0);
        send_cmd(1, -1, 1'b0, 1'b0);
`endif

        // Random command traffic with concurrent temperature/doorbell activity.
        cyc       = 0;
        last_edge = -1000;
        prev_btn  = 1'b0;
        bg_run    = 1'b1;
        fork
            bg_loop();
            begin
                for (int n = 0; n < 25; n++) begin
`ifdef CLOSE_CMD_EN
                    kind = int'($urandom_range(0, 2));
`else
                    kind = 0;
`endif
                    s  = cmd_text(kind);
                    ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, s.len() - 1)) : -1;
                    send_cmd(kind, ab, 1'b1, 1'b1);
                    repeat ($urandom_range(0, 3)) tick();
                end
                bg_run = 1'b0;
            end
        join
        repeat (RING + 2) tick();

        // Reset in the middle of the string, at character index 4.
        send_open = 1'b1; tick(); send_open = 1'b0;
        s = cmd_text(0);
        for (int i = 0; i < 5; i++) begin
            cnt = 0;
            while (!char_valid && cnt < 64) begin
                tick();
                cnt++;
            end
            if (i < 4) begin
                ack = 1'b1; tick(); ack = 1'b0;
            end
        end
        check_eq("mid_char", 32'(char_req), 32'(s[4]));
        #3;
        reset = 1'b0;
        #1;
        check_eq("async_valid", 32'(char_valid), 32'd0);
        check_eq("async_busy", 32'(busy), 32'd0);
        check_eq("async_char", 32'(char_req), 32'd0);
        check_eq("async_temp", temp_req, 32'(TRST));
        check_eq("async_ring", 32'(ring_req), 32'd0);
        #2;
        reset = 1'b1;
        tick();
        check_eq("no_resume_valid", 32'(char_valid), 32'd0);
        check_eq("no_resume_busy", 32'(busy), 32'd0);
        send_cmd(0, -1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
